vending_machine_multi: RTL

Parametrised successor to the three-product vending controller. Supports N products with a per-product price table, per-product inventory counters, a capped credit balance with coin rejection, and a valid/ack handshake for change return. Sits between the coin/keypad front end and the dispenser/coin-hopper drivers in the vending datapath.

---
 rtl/vm_pkg.sv | 18 +
 rtl/vm_inventory.sv | 38 +++
 rtl/vending_machine_multi.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: coin encoding, coin-value lookup and FSM state type for vending_machine_multi.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;
    localparam int         COIN_W    = 5;

    typedef enum logic {IDLE, CHANGE} state_t;

    function automatic logic [COIN_W-1:0] coin_value(input logic [1:0] code);
        return code == COIN_5  ? 5'd5  :
               code == COIN_10 ? 5'd10 :
               code == COIN_25 ? 5'd25 : 5'd0;
    endfunction

endpackage

// File: rtl/vm_inventory.sv
// vm_inventory: per-product stock counters with decrement/reload ports and sold_out flags.
module vm_inventory
    import vm_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int STOCK_W      = 3,
    parameter int INIT_STOCK   = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_dec,
    input  logic [$clog2(NUM_PRODUCTS)-1:0]   i_dec_idx,
    input  logic                              i_reload,
    input  logic [$clog2(NUM_PRODUCTS)-1:0]   i_reload_idx,
    output logic [NUM_PRODUCTS*STOCK_W-1:0]   o_stock,
    output logic [NUM_PRODUCTS-1:0]           o_sold_out
);

    localparam int IDX_W = $clog2(NUM_PRODUCTS);

    genvar i;
    generate
        for (i = 0; i < NUM_PRODUCTS; i++) begin : g_cnt
            logic [STOCK_W-1:0] r_stock;
            always_ff @(posedge clk) begin
                if (rst)
                    r_stock <= STOCK_W'(INIT_STOCK);
                else if (i_reload && i_reload_idx == IDX_W'(i))
                    r_stock <= STOCK_W'(INIT_STOCK);
                else if (i_dec && i_dec_idx == IDX_W'(i) && r_stock != '0)
                    r_stock <= r_stock - 1'b1;
            end
            assign o_stock[i*STOCK_W +: STOCK_W] = r_stock;
            assign o_sold_out[i]                 = r_stock == '0;
        end
    endgenerate

endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: N-product vending FSM with capped credit and change handshake.
// Optional VM_RESTOCK_EN adds restock/restock_idx ports for per-product reload.
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int                              NUM_PRODUCTS = 4,
    parameter int                              BAL_W        = 6,
    parameter int                              STOCK_W      = 3,
    parameter int                              INIT_STOCK   = 3,
    parameter int                              MAX_BALANCE  = 60,
    parameter logic [NUM_PRODUCTS*BAL_W-1:0]   PRICE_LIST   = {6'd25, 6'd20, 6'd15, 6'd5}
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef VM_RESTOCK_EN
    input  logic                              restock,
    input  logic [$clog2(NUM_PRODUCTS)-1:0]   restock_idx,
`endif
    input  logic [1:0]                        coin_input,
    input  logic                              sel_valid,
    input  logic [$clog2(NUM_PRODUCTS)-1:0]   sel_idx,
    input  logic                              cancel,
    input  logic                              change_ack,
    output logic [NUM_PRODUCTS-1:0]           dispense,
    output logic [BAL_W-1:0]                  change_return,
    output logic                              change_valid,
    output logic [BAL_W-1:0]                  balance,
    output logic                              coin_reject,
    output logic                              vend_fail,
    output logic [NUM_PRODUCTS-1:0]           sold_out,
    output logic                              busy
);

    localparam int IDX_W = $clog2(NUM_PRODUCTS);

    state_t                         r_state, w_state;
    logic [BAL_W-1:0]               r_balance, w_balance, r_change, w_change;
    logic [NUM_PRODUCTS-1:0]        r_dispense, w_dispense;
    logic                           r_coin_reject, w_coin_reject, r_vend_fail, w_vend_fail;
    logic [BAL_W-1:0]               w_coin_val, w_room, w_price;
    logic                           w_coin, w_sel_hit, w_dec, w_reload, w_rs_hit;
    logic [STOCK_W-1:0]             w_sel_stock;
    logic [NUM_PRODUCTS*STOCK_W-1:0] w_stock;
    logic [IDX_W-1:0]               w_reload_idx;

    assign w_coin     = coin_input != COIN_NONE;
    assign w_coin_val = BAL_W'(coin_value(coin_input));
    // Headroom compare avoids ever forming balance+coin, which could wrap at BAL_W
    assign w_room     = BAL_W'(MAX_BALANCE) - r_balance;

`ifdef VM_RESTOCK_EN
    assign w_reload_idx = restock_idx;
`else
    assign w_reload_idx = '0;
`endif

    always_comb begin
        w_sel_hit   = 1'b0;
        w_price     = '0;
        w_sel_stock = '0;
        w_rs_hit    = 1'b0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                w_sel_hit   = 1'b1;
                w_price     = PRICE_LIST[i*BAL_W +: BAL_W];
                w_sel_stock = w_stock[i*STOCK_W +: STOCK_W];
            end
            if (w_reload_idx == IDX_W'(i))
                w_rs_hit = 1'b1;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_balance     = r_balance;
        w_change      = r_change;
        w_dispense    = '0;
        w_coin_reject = 1'b0;
        w_vend_fail   = 1'b0;
        w_dec         = 1'b0;
        w_reload      = 1'b0;
        if (r_state == CHANGE) begin
            w_coin_reject = w_coin;
            if (change_ack) begin
                w_state  = IDLE;
                w_change = '0;
            end
        end else if (cancel) begin
            w_coin_reject = w_coin;
            if (r_balance != '0) begin
                w_change  = r_balance;
                w_balance = '0;
                w_state   = CHANGE;
            end
        end else if (sel_valid) begin
            w_coin_reject = w_coin;
            if (!w_sel_hit || w_sel_stock == '0 || r_balance < w_price)
                w_vend_fail = 1'b1;
            else begin
                w_dispense = NUM_PRODUCTS'(1) << sel_idx;
                w_dec      = 1'b1;
                w_change   = r_balance - w_price;
                w_balance  = '0;
                w_state    = r_balance != w_price ? CHANGE : IDLE;
            end
        end else if (w_coin) begin
            if (w_coin_val <= w_room)
                w_balance = r_balance + w_coin_val;
            else
                w_coin_reject = 1'b1;
        end
`ifdef VM_RESTOCK_EN
        else
            w_reload = restock && w_rs_hit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_balance     <= '0;
            r_change      <= '0;
            r_dispense    <= '0;
            r_coin_reject <= 1'b0;
            r_vend_fail   <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_balance     <= w_balance;
            r_change      <= w_change;
            r_dispense    <= w_dispense;
            r_coin_reject <= w_coin_reject;
            r_vend_fail   <= w_vend_fail;
        end
    end

    vm_inventory #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .STOCK_W      (STOCK_W),
        .INIT_STOCK   (INIT_STOCK)
    ) u_inv (
        .clk          (clk),
        .rst          (rst),
        .i_dec        (w_dec),
        .i_dec_idx    (sel_idx),
        .i_reload     (w_reload),
        .i_reload_idx (w_reload_idx),
        .o_stock      (w_stock),
        .o_sold_out   (sold_out)
    );

    assign dispense      = r_dispense;
    assign change_return = r_change;
    assign change_valid  = r_state == CHANGE;
    assign busy          = r_state == CHANGE;
    assign balance       = r_balance;
    assign coin_reject   = r_coin_reject;
    assign vend_fail     = r_vend_fail;

endmodule
